// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types and constants.
package legv8_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/flopr_en.sv
// Resettable register with load enable; synchronous active-low reset.
module flopr_en #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/fetch_ifid.sv
// LEGv8 instruction fetch with IF/ID pipeline register, one-entry skid buffer
// for stalled returns, and kill of in-flight fetches on branch redirect.
module fetch_ifid
  import legv8_pkg::*;
#(
  parameter int unsigned   N        = 64,
  parameter int unsigned   IW       = INSTR_W,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          pc_src,
  input  logic [N-1:0]  pc_branch,
  input  logic          stall,
  input  logic          flush,
  output logic [N-1:0]  ifid_pc,
  output logic [IW-1:0] ifid_instr,
  output logic          ifid_valid
);

  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

  fetch_state_t  state_q, state_d;
  logic          kill_q, kill_d;
  logic          req_q, req_d;
  logic [N-1:0]  pc_q, pc_d, addr_q, addr_d;
  logic [N-1:0]  buf_pc_q, ifid_pc_d;
  logic [IW-1:0] buf_instr_q, ifid_instr_d;
  logic          ifid_valid_d;
  logic          pc_en, buf_en, ifid_ld_en;
  logic          ack_fire, take;

  assign ack_fire = (state_q == REQ) && imem_ack;
  assign take     = ack_fire && !kill_q;

  // Next-state, redirect/kill and IF/ID load control.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    pc_d         = pc_q;
    pc_en        = 1'b0;
    buf_en       = 1'b0;
    ifid_ld_en   = 1'b0;
    ifid_pc_d    = pc_q;
    ifid_instr_d = imem_rdata;
    ifid_valid_d = ifid_valid;

    if (pc_src) begin
      pc_d         = pc_branch & ALIGN_MASK;
      pc_en        = 1'b1;
      state_d      = REQ;
      kill_d       = (state_q == REQ) && !imem_ack;
      ifid_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          if (!stall) ifid_valid_d = 1'b0;
        end
        REQ: begin
          if (ack_fire) kill_d = 1'b0;
          if (take) begin
            pc_d  = pc_q + N'(PC_INC);
            pc_en = 1'b1;
            if (stall) begin
              buf_en  = 1'b1;
              state_d = HOLD;
            end else begin
              ifid_ld_en   = 1'b1;
              ifid_valid_d = 1'b1;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_ld_en   = 1'b1;
            ifid_pc_d    = buf_pc_q;
            ifid_instr_d = buf_instr_q;
            ifid_valid_d = 1'b1;
            state_d      = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (flush) ifid_valid_d = 1'b0;

    // A killed request keeps presenting its original address until acked.
    addr_d = kill_d ? addr_q : pc_d;
    req_d  = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
    end
  end

  flopr_en #(.W(N), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
  );

  flopr_en #(.W(N), .RST_VAL(RESET_PC)) u_addr (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(addr_d), .q_o(addr_q)
  );

  flopr_en #(.W(N)) u_buf_pc (
    .clk(clk), .reset(reset), .en_i(buf_en), .d_i(pc_q), .q_o(buf_pc_q)
  );

  flopr_en #(.W(IW)) u_buf_instr (
    .clk(clk), .reset(reset), .en_i(buf_en), .d_i(imem_rdata), .q_o(buf_instr_q)
  );

  flopr_en #(.W(N)) u_ifid_pc (
    .clk(clk), .reset(reset), .en_i(ifid_ld_en), .d_i(ifid_pc_d), .q_o(ifid_pc)
  );

  flopr_en #(.W(IW)) u_ifid_instr (
    .clk(clk), .reset(reset), .en_i(ifid_ld_en), .d_i(ifid_instr_d), .q_o(ifid_instr)
  );

  flopr_en #(.W(1)) u_ifid_valid (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i(ifid_valid_d), .q_o(ifid_valid)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

endmodule
